// File: rtl/dmux16_buf.sv
// dmux16_buf: 1-to-2 demultiplexer with a one-entry ready/valid buffer per channel.
// The word on `in` is routed to channel a (sel=0) or channel b (sel=1).
// Each channel is a single register slot that can be refilled while it drains.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   in[15:0], sel, in_valid  source word, its destination channel, and its valid flag
//   in_ready                 combinational; the selected channel can take a word this cycle
//   a[15:0], a_valid         channel-a word and valid flag (registered)
//   a_ready                  channel-a sink accepts the word
//   b[15:0], b_valid         channel-b word and valid flag (registered)
//   b_ready                  channel-b sink accepts the word
//   cnt_a, cnt_b [15:0]      completed output transfers per channel; wrap at 16 bits
//                            (present only when DMUX16_BUF_CNT_EN is defined)
// Parameter IDLE_ZERO: 1 -> a/b read 0 while empty; 0 -> a/b keep the last loaded word.
// Optional feature macro: DMUX16_BUF_CNT_EN (adds the transfer counters).
module dmux16_buf #(
    parameter int unsigned IDLE_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] a,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [15:0] b,
    output logic        b_valid,
    input  logic        b_ready
`ifdef DMUX16_BUF_CNT_EN
    ,
    output logic [15:0] cnt_a,
    output logic [15:0] cnt_b
`endif
);

    localparam int unsigned DATA_W = 16;
    localparam bit CLR_ON_EMPTY = (IDLE_ZERO != 0);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t a_state, a_state_nxt;
    state_t b_state, b_state_nxt;
    logic [DATA_W-1:0] a_data, b_data;
    logic a_load, b_load, a_drain, b_drain;

    // Valid flags come straight from the state registers.
    assign a_valid = (a_state == FULL);
    assign b_valid = (b_state == FULL);
    assign a = a_data;
    assign b = b_data;

    // Only the selected channel gates the source; the other may stall freely.
    assign in_ready = sel ? (!b_valid || b_ready) : (!a_valid || a_ready);

    assign a_load  = in_valid && in_ready && !sel;
    assign b_load  = in_valid && in_ready &&  sel;
    assign a_drain = a_valid && a_ready;
    assign b_drain = b_valid && b_ready;

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
        end else begin
            a_state <= a_state_nxt;
            b_state <= b_state_nxt;
        end
    end

    // Next-state: a load always leaves the slot full; a drain alone empties it.
    always_comb begin
        a_state_nxt = a_state;
        b_state_nxt = b_state;
        case (a_state)
            EMPTY:   if (a_load) a_state_nxt = FULL;
            FULL:    if (a_drain && !a_load) a_state_nxt = EMPTY;
            default: a_state_nxt = EMPTY;
        endcase
        case (b_state)
            EMPTY:   if (b_load) b_state_nxt = FULL;
            FULL:    if (b_drain && !b_load) b_state_nxt = EMPTY;
            default: b_state_nxt = EMPTY;
        endcase
    end

    // Data slots; when IDLE_ZERO is set a slot is cleared as it goes empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_load)
                a_data <= in;
            else if (a_drain && CLR_ON_EMPTY)
                a_data <= '0;
            if (b_load)
                b_data <= in;
            else if (b_drain && CLR_ON_EMPTY)
                b_data <= '0;
        end
    end

`ifdef DMUX16_BUF_CNT_EN
    // Output transfer counters; natural 16-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_drain) cnt_a <= cnt_a + 16'd1;
            if (b_drain) cnt_b <= cnt_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmux16_buf.sv
// tb_dmux16_buf: directed, table-driven bench for dmux16_buf.
// Instantiates the default (IDLE_ZERO=1) block and an IDLE_ZERO=0 copy on the same inputs.
module tb_dmux16_buf;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        sel;
    logic        in_valid;
    logic        a_ready;
    logic        b_ready;
    logic        in_ready, in_ready0;
    logic [15:0] a, b, a0, b0;
    logic        a_valid, b_valid, a_valid0, b_valid0;
`ifdef DMUX16_BUF_CNT_EN
    logic [15:0] cnt_a, cnt_b, cnt_a0, cnt_b0;
`endif

    int checks;
    int errors;

    dmux16_buf #(.IDLE_ZERO(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in(din), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .a_valid(a_valid), .a_ready(a_ready),
        .b(b), .b_valid(b_valid), .b_ready(b_ready)
`ifdef DMUX16_BUF_CNT_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
    );

    dmux16_buf #(.IDLE_ZERO(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in(din), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready0), .a(a0), .a_valid(a_valid0), .a_ready(a_ready),
        .b(b0), .b_valid(b_valid0), .b_ready(b_ready)
`ifdef DMUX16_BUF_CNT_EN
        , .cnt_a(cnt_a0), .cnt_b(cnt_b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d,
                         input logic ar, input logic br);
        in_valid = v;
        sel      = s;
        din      = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic av, input logic [15:0] ea,
                           input logic bv, input logic [15:0] eb);
        chk({tag, ".a_valid"}, 32'(a_valid), 32'(av));
        chk({tag, ".a"},       32'(a),       32'(ea));
        chk({tag, ".b_valid"}, 32'(b_valid), 32'(bv));
        chk({tag, ".b"},       32'(b),       32'(eb));
    endtask

    // Inputs applied before an edge, in_ready expected before that edge, outputs after it.
    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic        ar;
        logic        br;
        logic        rdy;
        logic        av;
        logic [15:0] ea;
        logic        bv;
        logic [15:0] eb;
    } vec_t;

    localparam int unsigned NVEC = 23;
    vec_t vec [NVEC];

    initial begin
        checks = 0;
        errors = 0;

        // Basic routing, then a drain.
        vec[0]  = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000};
        vec[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        // Backpressure on b.
        vec[2]  = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
        vec[3]  = '{1'b1, 1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
        vec[4]  = '{1'b1, 1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
        vec[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
        vec[6]  = '{1'b1, 1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hCAFE};
        vec[7]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        // Full throughput on a: 1..8 back-to-back.
        for (int k = 0; k < 8; k++)
            vec[8+k] = '{1'b1, 1'b0, 16'(k+1), 1'b1, 1'b1, 1'b1, 1'b1, 16'(k+1), 1'b0, 16'h0000};
        vec[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        // in_valid=0 ignores sel/in.
        vec[17] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        // Channel independence: a stalled, b keeps flowing.
        vec[18] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 16'h0000};
        vec[19] = '{1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 16'h2222};
        vec[20] = '{1'b1, 1'b0, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 16'h0000};
        vec[21] = '{1'b1, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b1, 16'h4444};
        vec[22] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};

        // Reset state.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        #2;
        chk_out("reset", 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vec[i].v, vec[i].s, vec[i].d, vec[i].ar, vec[i].br);
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vec[i].rdy));
            tick();
            chk_out($sformatf("v%0d", i), vec[i].av, vec[i].ea, vec[i].bv, vec[i].eb);
        end

        // Reset between edges with both channels full.
        drive(1'b1, 1'b0, 16'h00AA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'h00BB, 1'b0, 1'b0);
        tick();
        chk_out("full", 1'b1, 16'h00AA, 1'b1, 16'h00BB);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 1'b0, 16'h9999, 1'b0, 1'b0);
        tick();
        chk_out("rst_hold", 1'b0, 16'h0000, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("post_rst", 1'b0, 16'h0000, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 16'h0077, 1'b0, 1'b0);
        tick();
        chk_out("first_load", 1'b1, 16'h0077, 1'b0, 16'h0000);

        // IDLE_ZERO=0 keeps the last word after draining; IDLE_ZERO=1 clears it.
        drive(1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b0);
        tick();
        chk("iz0.a_valid_load", 32'(a_valid0), 32'd1);
        chk("iz0.a_load", 32'(a0), 32'h5A5A);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("iz0.a_valid_drained", 32'(a_valid0), 32'd0);
        chk("iz0.a_drained", 32'(a0), 32'h5A5A);
        chk("iz1.a_drained", 32'(a), 32'h0000);

`ifdef DMUX16_BUF_CNT_EN
        // Counter wrap: 65537 channel-a transfers.
        rst_n = 1'b0;
        #1;
        chk("cnt.rst_a", 32'(cnt_a), 32'd0);
        chk("cnt.rst_b", 32'(cnt_b), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'h00C3, 1'b1, 1'b0);
        repeat (65537) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("cnt.wrap_a", 32'(cnt_a), 32'd1);
        chk("cnt.wrap_b", 32'(cnt_b), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux16_buf.md
DMUX16_BUF -- requirements
Module: dmux16_buf

Interface
REQ-001 The block SHALL have parameter IDLE_ZERO, default 1: when 1, a/b are driven to 16'h0000 while the matching valid is low; when 0, a/b hold their last loaded word.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in, input, 16 bits: the source data word.
REQ-005 The block SHALL have port sel, input, 1 bit: destination of the word on in (0 -> channel a, 1 -> channel b); sampled with in.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in/sel carry a word.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have port a, output, 16 bits: channel-a data.
REQ-009 The block SHALL have port a_valid, output, 1 bit: a holds a word.
REQ-010 The block SHALL have port a_ready, input, 1 bit: the channel-a sink takes the word.
REQ-011 The block SHALL have ports b, b_valid and b_ready, defined identically to a, a_valid and a_ready for channel b.

Function
REQ-012 Each channel SHALL be a one-entry buffer with two states: EMPTY (valid=0) and FULL (valid=1).
REQ-013 in_ready SHALL be combinational: sel ? (!b_valid | b_ready) : (!a_valid | a_ready); no dependence on in_valid.
REQ-014 A transfer on the input SHALL occur when in_valid & in_ready; the word SHALL load into the channel named by sel.
REQ-015 Latency SHALL be one cycle: a word accepted at edge N is on a/b with valid=1 after edge N.
REQ-016 An output transfer SHALL occur when x_valid & x_ready (x = a or b).
REQ-017 EMPTY -> FULL on a load; FULL -> EMPTY on a drain with no load; FULL -> FULL on a simultaneous load and drain, with the new word replacing the old one (full throughput, no bubble).
REQ-018 While x_valid=1 and x_ready=0, x SHALL remain stable.
REQ-019 The channels SHALL be independent: a stall on one channel SHALL block input only while sel selects that channel.
REQ-020 Word order within each channel SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-021 in_valid=0 SHALL leave both channels unaffected, whatever the value of sel or in.

Reset
REQ-022 While rst_n=0: a_valid=0, b_valid=0, a=16'h0000, b=16'h0000, and counters (if present) at 0.
REQ-023 in_ready during reset SHALL follow REQ-013, so it reads 1 because both channels are EMPTY.
REQ-024 Reset asserted mid-transfer SHALL discard buffered words immediately, without waiting for a clock edge.
REQ-025 After rst_n deasserts, the first accepted word SHALL appear one cycle later, per REQ-015.

Configuration
REQ-026 Macro DMUX16_BUF_CNT_EN: when defined, the block SHALL add outputs cnt_a[15:0] and cnt_b[15:0].
REQ-027 With DMUX16_BUF_CNT_EN defined, cnt_a and cnt_b SHALL count completed output transfers per channel, increment 1 per transfer, wrap 16'hFFFF -> 16'h0000, and reset to 0.
REQ-028 Without DMUX16_BUF_CNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-029 Basic routing: after reset, in=16'h1234 with sel=0 and in_valid=1 for one cycle, a_ready=1 -> a=16'h1234 with a_valid=1 for exactly one cycle; b_valid stays 0.
REQ-030 Backpressure: b_ready=0; send 16'hBEEF then 16'hCAFE, both with sel=1 -> b holds 16'hBEEF stable; in_ready=0 while sel=1; in_ready=1 when sel=0; on b_ready=1, b sees BEEF then CAFE in order.
REQ-031 Full throughput: a_ready=1, with 8 back-to-back words 16'h0001..16'h0008 on sel=0 -> in_ready stays 1, and a shows 1..8 on consecutive cycles.
REQ-032 Reset mid-operation: both channels FULL (a=16'h00AA, b=16'h00BB), then pull rst_n low between edges -> a_valid=b_valid=0 and a=b=0 immediately, and stay so until the first load after release.
REQ-033 Counter wrap: with DMUX16_BUF_CNT_EN defined, 65537 channel-a transfers -> cnt_a=1 and cnt_b=0.
REQ-034 IDLE_ZERO=0: load 16'h5A5A on a, then drain it -> a_valid=0 and a still reads 16'h5A5A.
